// File: rtl/cordic_angle_rate_if.sv
// Handshake bundle for cordic_angle_rate: angle stream in, averaged rate out.
// Ports: angle_in/vld_in/clr/rate_rdy from producer side; rate_out/rate_vld/drop_err from the block.
interface cordic_angle_rate_if #(
  parameter int ANGLE_WIDTH = 16
);
  logic signed [ANGLE_WIDTH-1:0] angle_in;
  logic                          vld_in;
  logic                          clr;
  logic signed [ANGLE_WIDTH-1:0] rate_out;
  logic                          rate_vld;
  logic                          rate_rdy;
  logic                          drop_err;

  modport master (
    output angle_in, vld_in, clr, rate_rdy,
    input  rate_out, rate_vld, drop_err
  );

  modport slave (
    input  angle_in, vld_in, clr, rate_rdy,
    output rate_out, rate_vld, drop_err
  );
endinterface

// File: rtl/cordic_angle_rate.sv
// Phase-rate estimator: wrapped angle differences averaged over 2^LOG2_N samples.
// Ports: clk, rst_n (async low), io (slave): angle stream in, rate out via valid/ready.
module cordic_angle_rate #(
  parameter int ANGLE_WIDTH = 16,
  parameter int LOG2_N      = 3
) (
  input logic               clk,
  input logic               rst_n,
  cordic_angle_rate_if.slave io
);
  localparam int W  = ANGLE_WIDTH;
  localparam int DW = W + 2;
  localparam int AW = W + LOG2_N + 1;

  localparam logic [0:0] S_PRIME = 1'b0;
  localparam logic [0:0] S_ACC   = 1'b1;

  localparam logic signed [DW-1:0] HALF = DW'(11520);
  localparam logic signed [DW-1:0] FULL = DW'(23040);

  logic [0:0]            state;
  logic signed [W-1:0]   prev;
  logic signed [AW-1:0]  acc;
  logic [LOG2_N-1:0]     cnt;
  logic signed [W-1:0]   r_out;
  logic                  r_vld;
  logic                  r_drop;

  logic signed [DW-1:0]  d_raw;
  logic signed [DW-1:0]  d;
  logic signed [AW-1:0]  sum;
  logic signed [W-1:0]   res;
  logic                  step;
  logic                  last;
  logic                  room;

  always_comb begin
    d_raw = DW'(io.angle_in) - DW'(prev);
    d     = d_raw;
    unique case (1'b1)
      (d_raw >= HALF):  d = d_raw - FULL;
      (d_raw < -HALF):  d = d_raw + FULL;
      default:          d = d_raw;
    endcase
    sum = acc + AW'(d);
    res = W'(sum >>> LOG2_N);
  end

  assign step = io.vld_in && (state == S_ACC);
  assign last = step && (cnt == '1);
  // Output register is free if empty or being taken this edge.
  assign room = !r_vld || io.rate_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_PRIME;
      prev   <= '0;
      acc    <= '0;
      cnt    <= '0;
      r_out  <= '0;
      r_vld  <= 1'b0;
      r_drop <= 1'b0;
    end else if (io.clr) begin
      state  <= S_PRIME;
      prev   <= '0;
      acc    <= '0;
      cnt    <= '0;
      r_out  <= '0;
      r_vld  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (r_vld && io.rate_rdy) begin
        r_vld <= 1'b0;
      end
      if (io.vld_in) begin
        prev  <= io.angle_in;
        state <= S_ACC;
      end
      if (step) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
          if (room) begin
            r_out <= res;
            r_vld <= 1'b1;
          end else begin
            r_drop <= 1'b1;
          end
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign io.rate_out = r_out;
  assign io.rate_vld = r_vld;
  assign io.drop_err = r_drop;
endmodule

// File: tb/tb_cordic_angle_rate.sv
// Self-checking bench for cordic_angle_rate (LOG2_N=2): table vectors,
// hand-written handshake/clear/reset sequences and a random scoreboard run.
module tb_cordic_angle_rate;
  localparam int W = 16;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_angle_rate_if #(.ANGLE_WIDTH(W)) ifc();

  cordic_angle_rate #(
    .ANGLE_WIDTH(W),
    .LOG2_N(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(ifc.slave)
  );

  int checks = 0;
  int failures = 0;
  int n_pop = 0;
  logic signed [W-1:0] exp_q[$];

  typedef struct {
    int a[5];
    int e;
  } vec_t;
  vec_t tbl[6];

  int  m_prev;
  int  m_sum;
  int  m_cnt;
  bit  m_primed;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int fdiv4(input int s);
    int r;
    r = s % 4;
    if (r < 0) r += 4;
    return (s - r) / 4;
  endfunction

  task automatic m_reset();
    m_prev = 0;
    m_sum = 0;
    m_cnt = 0;
    m_primed = 0;
  endtask

  task automatic m_step(input int a);
    int d;
    if (!m_primed) begin
      m_primed = 1;
      m_prev = a;
    end else begin
      d = a - m_prev;
      if (d >= 11520) d -= 23040;
      else if (d < -11520) d += 23040;
      m_sum += d;
      m_cnt++;
      m_prev = a;
      if (m_cnt == 4) begin
        exp_q.push_back(W'(fdiv4(m_sum)));
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.rate_vld && ifc.rate_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %0d want none", ifc.rate_out);
      end else begin
        chk("rate_out", ifc.rate_out, exp_q.pop_front());
      end
      n_pop++;
    end
  end

  task automatic send(input int a);
    @(posedge clk);
    #1;
    ifc.angle_in = W'(a);
    ifc.vld_in = 1'b1;
    ifc.clr = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    ifc.vld_in = 1'b0;
    ifc.clr = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1;
    ifc.clr = 1'b1;
    ifc.vld_in = 1'b0;
    m_reset();
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      idle();
    end
    idle();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic ramp5();
    for (int i = 0; i < 5; i++) send(i * 64);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int a;
    ifc.angle_in = '0;
    ifc.vld_in = 1'b0;
    ifc.clr = 1'b0;
    ifc.rate_rdy = 1'b1;
    m_reset();

    tbl[0].a = '{1000, 1000, 1000, 1000, 1000};        tbl[0].e = 0;
    tbl[1].a = '{0, 64, 128, 192, 256};                tbl[1].e = 64;
    tbl[2].a = '{16000, -6000, -4960, -3920, -2880};   tbl[2].e = 1040;
    tbl[3].a = '{10, 9, 8, 7, 5};                      tbl[3].e = -2;
    tbl[4].a = '{-5760, 5760, -5760, 5760, -5760};     tbl[4].e = -11520;
    tbl[5].a = '{17280, 17000, 16000, 15000, 14001};   tbl[5].e = -820;

    #12;
    chk("rst_vld", ifc.rate_vld, 0);
    chk("rst_out", ifc.rate_out, 0);
    chk("rst_drop", ifc.drop_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: result visible one cycle after the 5th sample, gone the next.
    do_clr();
    for (int i = 0; i < 4; i++) send(1000);
    exp_q.push_back(0);
    send(1000);
    @(negedge clk);
    chk("t1_lat_pre", ifc.rate_vld, 0);
    idle();
    @(negedge clk);
    chk("t1_lat_vld", ifc.rate_vld, 1);
    chk("t1_lat_out", ifc.rate_out, 0);
    @(negedge clk);
    chk("t1_lat_clr", ifc.rate_vld, 0);

    // Back-to-back windows share the boundary sample.
    do_clr();
    for (int i = 0; i < 4; i++) send(i * 64);
    exp_q.push_back(64);
    send(256);
    n0 = n_pop;
    send(320);
    send(384);
    send(448);
    chk("t2_first_only", n_pop, n0 + 1);
    exp_q.push_back(64);
    send(512);
    drain();
    chk("t2_second", n_pop, n0 + 2);

    for (int v = 0; v < 6; v++) begin
      do_clr();
      n0 = n_pop;
      for (int j = 0; j < 5; j++) begin
        if (j == 4) exp_q.push_back(W'(tbl[v].e));
        send(tbl[v].a[j]);
      end
      drain();
      chk($sformatf("vec%0d_count", v), n_pop, n0 + 1);
      chk($sformatf("vec%0d_vld", v), ifc.rate_vld, 0);
    end

    // Second result dropped while the first is held.
    ifc.rate_rdy = 1'b0;
    do_clr();
    for (int i = 0; i < 4; i++) send(i * 64);
    exp_q.push_back(64);
    send(256);
    for (int i = 1; i <= 4; i++) send(256 + i * 128);
    idle();
    @(negedge clk);
    chk("t5_hold_vld", ifc.rate_vld, 1);
    chk("t5_hold_out", ifc.rate_out, 64);
    chk("t5_drop", ifc.drop_err, 1);
    @(posedge clk);
    #1;
    ifc.rate_rdy = 1'b1;
    idle();
    @(negedge clk);
    chk("t5_taken", ifc.rate_vld, 0);
    chk("t5_sticky", ifc.drop_err, 1);
    chk("t5_q", exp_q.size(), 0);
    do_clr();
    idle();
    @(negedge clk);
    chk("t5_clr_drop", ifc.drop_err, 0);

    // Ready on the cycle the second result forms: replaced, no drop.
    ifc.rate_rdy = 1'b0;
    do_clr();
    for (int i = 0; i < 4; i++) send(i * 64);
    exp_q.push_back(64);
    send(256);
    for (int i = 1; i <= 3; i++) send(256 + i * 128);
    exp_q.push_back(128);
    @(posedge clk);
    #1;
    ifc.angle_in = W'(768);
    ifc.vld_in = 1'b1;
    ifc.rate_rdy = 1'b1;
    @(posedge clk);
    #1;
    ifc.vld_in = 1'b0;
    ifc.rate_rdy = 1'b0;
    @(negedge clk);
    chk("t5b_vld", ifc.rate_vld, 1);
    chk("t5b_out", ifc.rate_out, 128);
    chk("t5b_drop", ifc.drop_err, 0);
    @(posedge clk);
    #1;
    ifc.rate_rdy = 1'b1;
    drain();

    // clr mid-window, with a sample in the clr cycle that must be ignored.
    do_clr();
    send(0);
    send(500);
    send(1000);
    @(posedge clk);
    #1;
    ifc.clr = 1'b1;
    ifc.vld_in = 1'b1;
    ifc.angle_in = W'(3000);
    n0 = n_pop;
    for (int i = 0; i < 4; i++) send(1000);
    idle();
    idle();
    idle();
    chk("t6_no_early", n_pop, n0);
    exp_q.push_back(0);
    send(1000);
    drain();
    chk("t6_count", n_pop, n0 + 1);

    // Async reset mid-window with a held result.
    ifc.rate_rdy = 1'b0;
    do_clr();
    ramp5();
    send(320);
    send(384);
    idle();
    @(negedge clk);
    chk("t6_pre_vld", ifc.rate_vld, 1);
    chk("t6_pre_out", ifc.rate_out, 64);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_vld", ifc.rate_vld, 0);
    chk("t6_arst_out", ifc.rate_out, 0);
    chk("t6_arst_drop", ifc.drop_err, 0);
    #2;
    rst_n = 1'b1;
    ifc.rate_rdy = 1'b1;
    m_reset();
    n0 = n_pop;
    for (int i = 0; i < 4; i++) send(1000);
    exp_q.push_back(0);
    send(1000);
    drain();
    chk("t6_post_rst", n_pop, n0 + 1);

    // Random legal angles against the reference model.
    do_clr();
    for (int i = 0; i < 41; i++) begin
      a = int'($urandom_range(23040)) - 5760;
      m_step(a);
      send(a);
    end
    drain();

    chk("final_q", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
